// File: rtl/tlul_host_driver.sv
// TL-UL host: turns a single-outstanding command/response handshake into one-beat
// Get / PutFullData / PutPartialData transactions, with timeout and stray-beat absorption.
package tlul_host_driver_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_driver
  import tlul_host_driver_pkg::*;
#(
  parameter logic [7:0]  SourceId      = 8'd0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output logic [7:0]  stray_cnt_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitD, StRsp} state_e;

  state_e      state_q;
  logic        cmd_ready_q, a_valid_q, d_ready_q, is_read_q;
  logic [2:0]  a_opcode_q;
  logic [1:0]  a_size_q;
  logic [7:0]  a_source_q;
  logic [31:0] a_address_q, a_data_q;
  logic [3:0]  a_mask_q;
  logic        rsp_valid_q, rsp_error_q, rsp_timeout_q;
  logic [31:0] rsp_rdata_q;
  logic [7:0]  stray_cnt_q;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_hit, stray_hit, d_rsp_err;
  logic [2:0]  exp_d_opcode;
  logic        unused_d_fields;

  assign tmo_cnt_d    = tmo_cnt_q + 32'd1;
  assign timeout_hit  = (TimeoutCycles != 0) && (tmo_cnt_d >= TimeoutCycles);
  // D beats outside WAIT_D are late answers to abandoned requests (or protocol noise).
  assign stray_hit    = tl_i.d_valid && d_ready_q && (state_q == StIdle || state_q == StReq);
  assign exp_d_opcode = is_read_q ? AccessAckData : AccessAck;
  assign d_rsp_err    = tl_i.d_error | (tl_i.d_source != SourceId) |
                        (tl_i.d_opcode != exp_d_opcode);
  assign unused_d_fields = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b1;
      a_valid_q     <= 1'b0;
      d_ready_q     <= 1'b1;
      is_read_q     <= 1'b0;
      a_opcode_q    <= 3'h0;
      a_size_q      <= 2'h0;
      a_source_q    <= 8'h0;
      a_address_q   <= 32'h0;
      a_data_q      <= 32'h0;
      a_mask_q      <= 4'h0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      stray_cnt_q   <= 8'h0;
      tmo_cnt_q     <= 32'h0;
    end else begin
      if (stray_hit && stray_cnt_q != 8'hFF) stray_cnt_q <= stray_cnt_q + 8'd1;
      case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_q) begin
            is_read_q   <= !cmd_write_i;
            a_opcode_q  <= !cmd_write_i ? Get :
                           (cmd_mask_i == 4'hF) ? PutFullData : PutPartialData;
            a_size_q    <= 2'h2;
            a_source_q  <= SourceId;
            a_address_q <= {cmd_addr_i[31:2], 2'b00};
            a_data_q    <= cmd_write_i ? cmd_wdata_i : 32'h0;
            a_mask_q    <= cmd_write_i ? cmd_mask_i : 4'hF;
            a_valid_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            tmo_cnt_q   <= 32'h0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          tmo_cnt_q <= tmo_cnt_d;
          if (tl_i.a_ready) begin
            a_valid_q <= 1'b0;
            state_q   <= StWaitD;
          end else if (timeout_hit) begin
            a_valid_q     <= 1'b0;
            d_ready_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= StRsp;
          end
        end
        StWaitD: begin
          tmo_cnt_q <= tmo_cnt_d;
          // A real response wins over a timeout expiring in the same cycle.
          if (tl_i.d_valid) begin
            d_ready_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= is_read_q ? tl_i.d_data : 32'h0;
            rsp_error_q   <= d_rsp_err;
            rsp_timeout_q <= 1'b0;
            state_q       <= StRsp;
          end else if (timeout_hit) begin
            d_ready_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            d_ready_q   <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign stray_cnt_o   = stray_cnt_q;

  assign tl_o = '{
    a_valid:   a_valid_q,
    a_opcode:  a_opcode_q,
    a_param:   3'h0,
    a_size:    a_size_q,
    a_source:  a_source_q,
    a_address: a_address_q,
    a_mask:    a_mask_q,
    a_data:    a_data_q,
    a_user:    16'h0,
    d_ready:   d_ready_q
  };

endmodule
